// File: rtl/cp0_intc_if.sv
// Bus between cp0_intc and the core: mtc0/mfc0/eret decode, exception entry and interrupt lines.
// master = core/controller side, slave = cp0_intc.
interface cp0_intc_if #(
    parameter int N_HWINT = 6
);
    logic [29:0]        PC;
    logic [31:0]        Din;
    logic [N_HWINT-1:0] HWInt;
    logic [2:0]         Sel;
    logic               Wen;
    logic               ExcReq;
    logic [4:0]         ExcCode;
    logic               BD;
    logic               EXLClr;
    logic               IntReq;
    logic [29:0]        EPC;
    logic [31:0]        DOut;

    modport master (
        output PC, Din, HWInt, Sel, Wen, ExcReq, ExcCode, BD, EXLClr,
        input  IntReq, EPC, DOut
    );

    modport slave (
        input  PC, Din, HWInt, Sel, Wen, ExcReq, ExcCode, BD, EXLClr,
        output IntReq, EPC, DOut
    );
endinterface

// File: rtl/cp0_intc.sv
// Coprocessor 0: SR, Cause, EPC, PRID, exception entry and interrupt request.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_intc #(
    parameter int          N_HWINT   = 6,
    parameter logic [31:0] PRID_VAL  = 32'h0000_4C01,
    parameter logic [29:0] EPC_RESET = 30'h0000_0C00
) (
    input logic       clk,
    input logic       reset,
    cp0_intc_if.slave bus
);
    typedef enum logic [2:0] {
        SEL_SR      = 3'd0,
        SEL_CAUSE   = 3'd1,
        SEL_EPC     = 3'd2,
        SEL_PRID    = 3'd3,
        SEL_COUNT   = 3'd4,
        SEL_COMPARE = 3'd5
    } sel_e;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [29:0] epc_q, epc_d;
    logic [5:0]  hw_ext;
    logic        ti;
    sel_e        sel;

    assign sel = sel_e'(bus.Sel);

    always_comb begin
        hw_ext = '0;
        hw_ext[N_HWINT-1:0] = bus.HWInt;
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    assign ti = ti_q;

    // Match uses the post-update Count; a Compare write in the same cycle clears TI regardless.
    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (bus.Wen && sel == SEL_COUNT) count_d = bus.Din;
        if (bus.Wen && sel == SEL_COMPARE) begin
            compare_d = bus.Din;
            ti_d      = 1'b0;
        end else if (count_d == compare_q && compare_q != '0) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end
`else
    logic unused_din;

    assign ti         = 1'b0;
    assign unused_din = ^{bus.Din[31:16], bus.Din[9:2]};
`endif

    // Later assignments override earlier ones: Wen < EXLClr < ExcReq.
    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        ip_d      = hw_ext;
        ip_d[5]   = hw_ext[5] | ti;

        if (bus.Wen && sel == SEL_SR) begin
            im_d  = bus.Din[15:10];
            exl_d = bus.Din[1];
            ie_d  = bus.Din[0];
        end
        if (bus.Wen && sel == SEL_EPC) epc_d = bus.Din[31:2];
        if (bus.EXLClr) exl_d = 1'b0;
        if (bus.ExcReq) begin
            exl_d     = 1'b1;
            exccode_d = bus.ExcCode;
            epc_d     = epc_q;
            if (!exl_q) begin
                bd_d  = bus.BD;
                epc_d = bus.BD ? bus.PC - 30'd1 : bus.PC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q      <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= '0;
            exccode_q <= '0;
            epc_q     <= EPC_RESET;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    assign bus.IntReq = (|(ip_q & im_q)) & ie_q & ~exl_q;
    assign bus.EPC    = epc_q;

    always_comb begin
        bus.DOut = '0;
        case (sel)
            SEL_SR:      bus.DOut = {16'b0, im_q, 8'b0, exl_q, ie_q};
            SEL_CAUSE:   bus.DOut = {bd_q, ti, 14'b0, ip_q, 3'b0, exccode_q, 2'b0};
            SEL_EPC:     bus.DOut = {epc_q, 2'b00};
            SEL_PRID:    bus.DOut = PRID_VAL;
`ifdef CP0_TIMER_EN
            SEL_COUNT:   bus.DOut = count_q;
            SEL_COMPARE: bus.DOut = compare_q;
`endif
            default:     bus.DOut = '0;
        endcase
    end
endmodule

// File: tb/tb_cp0_intc.sv
// Directed, table-driven bench for cp0_intc; timer checks are active when CP0_TIMER_EN is defined.
module tb_cp0_intc;
`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic clk;
    logic reset;
    int   ncmp;
    int   nfail;

    cp0_intc_if #(.N_HWINT(6)) bus ();

    cp0_intc #(
        .N_HWINT  (6),
        .PRID_VAL (32'h0000_4C01),
        .EPC_RESET(30'h0000_0C00)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [2:0]  wsel;
        logic [31:0] din;
        logic [5:0]  hw;
        logic        exc;
        logic [4:0]  code;
        logic        bd;
        logic [29:0] pc;
        logic        clr;
        logic [2:0]  rsel;
        logic [31:0] dout;
        logic        irq;
        logic [29:0] epc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.Wen     = 1'b0;
        bus.ExcReq  = 1'b0;
        bus.EXLClr  = 1'b0;
        bus.ExcCode = '0;
        bus.BD      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input logic [2:0] s, output logic [31:0] d);
        bus.Sel = s;
        #1;
        d = bus.DOut;
    endtask

    task automatic wr(input logic [2:0] s, input logic [31:0] d);
        bus.Sel = s;
        bus.Din = d;
        bus.Wen = 1'b1;
        tick();
    endtask

    initial begin
        logic [31:0] d;
        int          ti_edge;
        int          irq_edge;

        ncmp     = 0;
        nfail    = 0;
        reset    = 1'b1;
        bus.PC   = '0;
        bus.Din  = '0;
        bus.HWInt = '0;
        bus.Sel  = 3'd3;
        idle();

        //        wen wsel din            hw         exc code  bd pc        clr rsel dout           irq  epc
        vecs.push_back('{1'b1, 3'd0, 32'hFFFF_FFFF, 6'b000000, 1'b0, 5'd0, 1'b0, 30'h0, 1'b0, 3'd0, 32'h0000_FC03, 1'b0, 30'h0C00});
        vecs.push_back('{1'b1, 3'd1, 32'hFFFF_FFFF, 6'b000000, 1'b0, 5'd0, 1'b0, 30'h0, 1'b0, 3'd1, 32'h0000_0000, 1'b0, 30'h0C00});
        vecs.push_back('{1'b1, 3'd3, 32'hFFFF_FFFF, 6'b000000, 1'b0, 5'd0, 1'b0, 30'h0, 1'b0, 3'd3, 32'h0000_4C01, 1'b0, 30'h0C00});
        vecs.push_back('{1'b1, 3'd0, 32'h0000_1401, 6'b000000, 1'b0, 5'd0, 1'b0, 30'h0, 1'b0, 3'd0, 32'h0000_1401, 1'b0, 30'h0C00});
        vecs.push_back('{1'b0, 3'd0, 32'h0,         6'b000100, 1'b0, 5'd0, 1'b0, 30'h0, 1'b0, 3'd1, 32'h0000_1000, 1'b1, 30'h0C00});
        vecs.push_back('{1'b0, 3'd0, 32'h0,         6'b000010, 1'b0, 5'd0, 1'b0, 30'h0, 1'b0, 3'd1, 32'h0000_0800, 1'b0, 30'h0C00});
        vecs.push_back('{1'b0, 3'd0, 32'h0,         6'b000000, 1'b0, 5'd0, 1'b0, 30'h0, 1'b0, 3'd1, 32'h0000_0000, 1'b0, 30'h0C00});
        vecs.push_back('{1'b0, 3'd0, 32'h0,         6'b000000, 1'b1, 5'd4, 1'b1, 30'h0C10, 1'b0, 3'd1, 32'h8000_0010, 1'b0, 30'h0C0F});
        vecs.push_back('{1'b0, 3'd0, 32'h0,         6'b000100, 1'b0, 5'd0, 1'b0, 30'h0, 1'b0, 3'd0, 32'h0000_1403, 1'b0, 30'h0C0F});
        vecs.push_back('{1'b0, 3'd0, 32'h0,         6'b000100, 1'b1, 5'd8, 1'b0, 30'h0D00, 1'b0, 3'd1, 32'h8000_1020, 1'b0, 30'h0C0F});
        vecs.push_back('{1'b0, 3'd0, 32'h0,         6'b000100, 1'b0, 5'd0, 1'b0, 30'h0, 1'b1, 3'd0, 32'h0000_1401, 1'b1, 30'h0C0F});
        vecs.push_back('{1'b1, 3'd2, 32'h0000_4000, 6'b000000, 1'b1, 5'd0, 1'b0, 30'h0C20, 1'b1, 3'd2, 32'h0000_3080, 1'b0, 30'h0C20});
        vecs.push_back('{1'b0, 3'd0, 32'h0,         6'b000000, 1'b0, 5'd0, 1'b0, 30'h0, 1'b0, 3'd1, 32'h0000_0000, 1'b0, 30'h0C20});
        vecs.push_back('{1'b0, 3'd0, 32'h0,         6'b000000, 1'b0, 5'd0, 1'b0, 30'h0, 1'b1, 3'd0, 32'h0000_1401, 1'b0, 30'h0C20});
        vecs.push_back('{1'b1, 3'd0, 32'h0000_0400, 6'b000000, 1'b1, 5'd0, 1'b0, 30'h0C30, 1'b0, 3'd0, 32'h0000_0402, 1'b0, 30'h0C30});
        vecs.push_back('{1'b1, 3'd2, 32'h0000_5000, 6'b000000, 1'b0, 5'd0, 1'b0, 30'h0, 1'b0, 3'd2, 32'h0000_5000, 1'b0, 30'h1400});
        vecs.push_back('{1'b1, 3'd4, 32'd123,       6'b000000, 1'b0, 5'd0, 1'b0, 30'h0, 1'b0, 3'd4, TIMER ? 32'd123 : 32'd0, 1'b0, 30'h1400});
        vecs.push_back('{1'b1, 3'd5, 32'd77,        6'b000000, 1'b0, 5'd0, 1'b0, 30'h0, 1'b0, 3'd5, TIMER ? 32'd77 : 32'd0, 1'b0, 30'h1400});
        vecs.push_back('{1'b1, 3'd6, 32'hFFFF_FFFF, 6'b000000, 1'b0, 5'd0, 1'b0, 30'h0, 1'b0, 3'd6, 32'h0, 1'b0, 30'h1400});
        vecs.push_back('{1'b1, 3'd7, 32'hFFFF_FFFF, 6'b000000, 1'b0, 5'd0, 1'b0, 30'h0, 1'b0, 3'd7, 32'h0, 1'b0, 30'h1400});

        // Reset state
        tick();
        reset = 1'b0;
        rd(3'd3, d); chk("reset_prid", d, 32'h0000_4C01);
        rd(3'd0, d); chk("reset_sr", d, 32'h0);
        rd(3'd1, d); chk("reset_cause", d, 32'h0);
        rd(3'd2, d); chk("reset_epc_dout", d, 32'h0000_3000);
        chk("reset_epc", {2'b0, bus.EPC}, {2'b0, 30'h0C00});
        chk("reset_intreq", {31'b0, bus.IntReq}, 32'h0);

        foreach (vecs[i]) begin
            bus.Wen     = vecs[i].wen;
            bus.Sel     = vecs[i].wsel;
            bus.Din     = vecs[i].din;
            bus.HWInt   = vecs[i].hw;
            bus.ExcReq  = vecs[i].exc;
            bus.ExcCode = vecs[i].code;
            bus.BD      = vecs[i].bd;
            bus.PC      = vecs[i].pc;
            bus.EXLClr  = vecs[i].clr;
            tick();
            rd(vecs[i].rsel, d);
            chk($sformatf("vec%0d_dout", i), d, vecs[i].dout);
            chk($sformatf("vec%0d_intreq", i), {31'b0, bus.IntReq}, {31'b0, vecs[i].irq});
            chk($sformatf("vec%0d_epc", i), {2'b0, bus.EPC}, {2'b0, vecs[i].epc});
        end

        // DOut returns the pre-write value while an mtc0 is pending in the same cycle
        bus.Sel = 3'd0;
        bus.Din = 32'h0000_FC01;
        bus.Wen = 1'b1;
        #1;
        chk("prewrite_sr", bus.DOut, 32'h0000_0402);
        tick();
        rd(3'd0, d); chk("postwrite_sr", d, 32'h0000_FC01);
        wr(3'd0, 32'h0);

`ifdef CP0_TIMER_EN
        wr(3'd5, 32'd10);
        wr(3'd0, 32'h0000_8001);
        wr(3'd4, 32'd0);
        ti_edge  = 0;
        irq_edge = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            rd(3'd1, d);
            if (d[30] && ti_edge == 0) ti_edge = n;
            if (bus.IntReq && irq_edge == 0) irq_edge = n;
        end
        chk("timer_ti_edge", ti_edge, 32'd10);
        chk("timer_irq_edge", irq_edge, 32'd11);
        wr(3'd5, 32'd10);
        rd(3'd1, d); chk("timer_ti_clear", {31'b0, d[30]}, 32'h0);
        wr(3'd4, 32'hFFFF_FFFF);
        rd(3'd4, d); chk("count_loaded", d, 32'hFFFF_FFFF);
        tick();
        rd(3'd4, d); chk("count_wrap", d, 32'h0);
        wr(3'd0, 32'h0);
`else
        ti_edge  = 0;
        irq_edge = 0;
        rd(3'd1, d); chk("no_timer_ti", {31'b0, d[30]}, 32'h0);
`endif

        // Reset wins over a concurrent exception and SR write
        bus.Sel    = 3'd0;
        bus.Din    = 32'hFFFF_FFFF;
        bus.Wen    = 1'b1;
        bus.ExcReq = 1'b1;
        bus.PC     = 30'h0777;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        rd(3'd0, d); chk("rst_over_sr", d, 32'h0);
        chk("rst_over_epc", {2'b0, bus.EPC}, {2'b0, 30'h0C00});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
